uart_op_engine: RTL and testbench

- FPGA-side packet engine between the uart_rx and uart_tx blocks: parametrised successor to the fixed two-byte-in/one-byte-out accelerator path.
- Receives an opcode byte followed by NUM_OPERANDS operands of DATA_BYTES each.
- Folds the operands through the selected ALU op and streams the result back through uart_tx, LSB first.
- Adds opcode select, multi-byte operands, timeout abort and NAK signalling.

---
 rtl/uart_op_pkg.sv | 23 ++
 rtl/uart_op_engine_if.sv | 12 +
 rtl/uart_op_alu.sv | 25 ++
 rtl/uart_op_engine.sv | 162 ++++++++++++++++
 tb/tb_uart_op_engine.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/uart_op_pkg.sv
// Shared constants and types for the UART operation engine.
package uart_op_pkg;

  localparam logic [7:0] OP_ADD   = 8'h00;
  localparam logic [7:0] OP_SUB   = 8'h01;
  localparam logic [7:0] OP_MUL   = 8'h02;
  localparam logic [7:0] OP_XOR   = 8'h03;
  localparam logic [7:0] NAK_BYTE = 8'hEE;

  // Encoding is also what state_dbg shows on the LEDs.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RX_OPND = 3'd1,
    ACCUM   = 3'd2,
    TX_LOAD = 3'd3,
    TX_WAIT = 3'd4
  } state_t;

  function automatic logic opcode_valid(input logic [7:0] op);
    return op <= OP_XOR;
  endfunction

endpackage

// File: rtl/uart_op_engine_if.sv
// Byte handshake between uart_rx/uart_tx and the operation engine.
// master: engine side; slave: UART side.
interface uart_op_engine_if;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_done;

  modport master (input rx_valid, rx_data, tx_done, output tx_start, tx_data);
  modport slave  (output rx_valid, rx_data, tx_done, input tx_start, tx_data);
endinterface

// File: rtl/uart_op_alu.sv
// Combinational RW-wide ALU: one fold step acc OP operand, modulo 2^RW.
module uart_op_alu
  import uart_op_pkg::*;
#(
  parameter int unsigned RW = 16
) (
  input  logic [7:0]    opcode,
  input  logic [RW-1:0] acc,
  input  logic [RW-1:0] operand,
  output logic [RW-1:0] result
);

  // Select the operation; MUL keeps only the low RW bits.
  always_comb begin
    result = acc;
    case (opcode)
      OP_ADD:  result = acc + operand;
      OP_SUB:  result = acc - operand;
      OP_MUL:  result = acc * operand;
      OP_XOR:  result = acc ^ operand;
      default: result = acc;
    endcase
  end

endmodule

// File: rtl/uart_op_engine.sv
// UART packet engine: opcode + NUM_OPERANDS operands in, folded result out
// LSB first. Define UART_OP_CHECKSUM_EN to append an XOR trailer byte.
module uart_op_engine
  import uart_op_pkg::*;
#(
  parameter int unsigned DATA_BYTES     = 1,
  parameter int unsigned NUM_OPERANDS   = 2,
  parameter int unsigned RESULT_BYTES   = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic                clk,
  input  logic                reset,
  uart_op_engine_if.master    bus,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [2:0]          state_dbg
);

  localparam int unsigned DW  = 8 * DATA_BYTES;
  localparam int unsigned RW  = 8 * RESULT_BYTES;
  localparam int unsigned BCW = $clog2(DATA_BYTES) + 1;
  localparam int unsigned OCW = $clog2(NUM_OPERANDS) + 1;
  localparam int unsigned ICW = $clog2(RESULT_BYTES + 2) + 1;
  localparam int unsigned TCW = $clog2(TIMEOUT_CYCLES + 1) + 1;
`ifdef UART_OP_CHECKSUM_EN
  localparam int unsigned TRAILER = 1;
`else
  localparam int unsigned TRAILER = 0;
`endif

  state_t           state;
  logic [7:0]       opcode;
  logic [DW-1:0]    opnd;
  logic [DW-1:0]    opnd_shift;
  logic [RW-1:0]    acc;
  logic [RW-1:0]    opnd_ext;
  logic [RW-1:0]    alu_out;
  logic [BCW-1:0]   byte_cnt;
  logic [OCW-1:0]   opnd_cnt;
  logic [ICW-1:0]   idx;
  logic [ICW-1:0]   tx_last;
  logic [TCW-1:0]   tmo_cnt;
  logic             nak;
  logic [7:0]       csum;
  logic [7:0]       tx_byte;

  assign opnd_shift = (opnd >> 8) | (DW'(bus.rx_data) << (DW - 8));
  assign opnd_ext   = RW'(opnd);
  assign tx_last    = nak ? ICW'(TRAILER) : ICW'(RESULT_BYTES - 1 + TRAILER);
  assign busy       = (state != IDLE);
  assign state_dbg  = state;

  uart_op_alu #(.RW(RW)) u_alu (
    .opcode  (opcode),
    .acc     (acc),
    .operand (opnd_ext),
    .result  (alu_out)
  );

  // Pick the next response byte: NAK, a result byte, or the XOR trailer.
  always_comb begin
    csum = '0;
    for (int unsigned i = 0; i < RESULT_BYTES; i++) csum ^= acc[8*i +: 8];
    if (nak)                              tx_byte = NAK_BYTE;
    else if (idx < ICW'(RESULT_BYTES))    tx_byte = 8'(acc >> (8 * idx));
    else                                  tx_byte = csum;
  end

  // Packet FSM with operand assembly, inter-byte timeout and response sequencing.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      opcode   <= '0;
      opnd     <= '0;
      acc      <= '0;
      byte_cnt <= '0;
      opnd_cnt <= '0;
      idx      <= '0;
      tmo_cnt  <= '0;
      nak      <= 1'b0;
      bus.tx_start <= 1'b0;
      bus.tx_data  <= '0;
      done     <= 1'b0;
      error    <= 1'b0;
    end else begin
      bus.tx_start <= 1'b0;
      done         <= 1'b0;

      // An arriving byte always restarts the timeout, even on the expiry cycle.
      if (bus.rx_valid)
        tmo_cnt <= '0;
      else if ((state == RX_OPND || state == ACCUM) && tmo_cnt != TCW'(TIMEOUT_CYCLES))
        tmo_cnt <= tmo_cnt + 1'b1;

      case (state)
        IDLE: begin
          if (bus.rx_valid) begin
            idx <= '0;
            if (opcode_valid(bus.rx_data)) begin
              opcode   <= bus.rx_data;
              error    <= 1'b0;
              nak      <= 1'b0;
              byte_cnt <= '0;
              opnd_cnt <= '0;
              state    <= RX_OPND;
            end else begin
              error <= 1'b1;
              nak   <= 1'b1;
              state <= TX_LOAD;
            end
          end
        end
        RX_OPND: begin
          if (bus.rx_valid) begin
            opnd <= opnd_shift;
            if (byte_cnt == BCW'(DATA_BYTES - 1)) begin
              byte_cnt <= '0;
              state    <= ACCUM;
            end else begin
              byte_cnt <= byte_cnt + 1'b1;
            end
          end else if (tmo_cnt >= TCW'(TIMEOUT_CYCLES - 1)) begin
            error <= 1'b1;
            state <= IDLE;
          end
        end
        ACCUM: begin
          if (bus.rx_valid) error <= 1'b1;
          acc <= (opnd_cnt == '0) ? opnd_ext : alu_out;
          if (opnd_cnt == OCW'(NUM_OPERANDS - 1)) begin
            idx   <= '0;
            state <= TX_LOAD;
          end else begin
            opnd_cnt <= opnd_cnt + 1'b1;
            state    <= RX_OPND;
          end
        end
        TX_LOAD: begin
          if (bus.rx_valid) error <= 1'b1;
          bus.tx_start <= 1'b1;
          bus.tx_data  <= tx_byte;
          state        <= TX_WAIT;
        end
        TX_WAIT: begin
          if (bus.rx_valid) error <= 1'b1;
          if (bus.tx_done) begin
            if (idx == tx_last) begin
              done  <= 1'b1;
              state <= IDLE;
            end else begin
              idx   <= idx + 1'b1;
              state <= TX_LOAD;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_op_engine.sv
// Self-checking bench for uart_op_engine; expected response bytes are queued
// when a packet is sent and compared as tx_start pulses appear.
module tb_uart_op_engine;
  import uart_op_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       busy, done, error;
  logic [2:0] state_dbg;

  uart_op_engine_if bus();

  uart_op_engine #(.TIMEOUT_CYCLES(50)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int tx_start_cnt = 0;
  logic [7:0] sb[$];

  always @(posedge clk) if (bus.tx_start === 1'b1) tx_start_cnt++;

  function automatic logic [15:0] model(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [15:0] x, y;
    x = {8'h00, a};
    y = {8'h00, b};
    case (op)
      8'h00:   return x + y;
      8'h01:   return x - y;
      8'h02:   return x * y;
      default: return x ^ y;
    endcase
  endfunction

  task automatic push_expected(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [15:0] r;
    if (op > 8'h03) begin
      sb.push_back(8'hEE);
`ifdef UART_OP_CHECKSUM_EN
      sb.push_back(8'hEE);
`endif
    end else begin
      r = model(op, a, b);
      sb.push_back(r[7:0]);
      sb.push_back(r[15:8]);
`ifdef UART_OP_CHECKSUM_EN
      sb.push_back(r[7:0] ^ r[15:8]);
`endif
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    @(posedge clk); #1;
    bus.rx_valid = 1'b0;
    @(posedge clk);
  endtask

  // Acts as uart_tx: acknowledges every tx_start and scores the byte.
  task automatic drain(input string name);
    int n;
    logic [7:0] exp;
    logic last;
    while (sb.size() > 0) begin
      n = 0;
      @(negedge clk);
      while (bus.tx_start !== 1'b1 && n < 200) begin
        @(negedge clk);
        n++;
      end
      if (bus.tx_start !== 1'b1) begin
        checks++; errors++;
        $display("FAIL %s tx_start: none within 200 cycles, %0d bytes expected", name, sb.size());
        sb.delete();
        return;
      end
      exp = sb.pop_front();
      checks++;
      if (bus.tx_data !== exp) begin
        errors++;
        $display("FAIL %s tx_data: got %02h expected %02h", name, bus.tx_data, exp);
      end
      last = (sb.size() == 0);
      repeat (3) @(posedge clk);
      #1 bus.tx_done = 1'b1;
      @(posedge clk);
      #1 bus.tx_done = 1'b0;
      @(negedge clk);
      if (last) begin
        checks++;
        if (done !== 1'b1) begin
          errors++;
          $display("FAIL %s done: got %b expected 1", name, done);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
          errors++;
          $display("FAIL %s done_once: got done=%b busy=%b expected 0 0", name, done, busy);
        end
      end
    end
  endtask

  task automatic test_packet(input string name, input logic [7:0] op, input logic [7:0] a, input logic [7:0] b);
    push_expected(op, a, b);
    send_byte(op);
    send_byte(a);
    send_byte(b);
    drain(name);
    checks++;
    if (error !== 1'b0) begin
      errors++;
      $display("FAIL %s error: got %b expected 0", name, error);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if (bus.tx_start !== 1'b0 || bus.tx_data !== 8'h00 || busy !== 1'b0 ||
        done !== 1'b0 || error !== 1'b0 || state_dbg !== 3'd0) begin
      errors++;
      $display("FAIL %s: got start=%b data=%02h busy=%b done=%b err=%b st=%0d expected 0 00 0 0 0 0",
               name, bus.tx_start, bus.tx_data, busy, done, error, state_dbg);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset_state");
    reset = 1'b1;
  endtask

  task automatic test_nak_then_xor();
    push_expected(8'h09, 8'h00, 8'h00);
    send_byte(8'h09);
    drain("nak");
    checks++;
    if (error !== 1'b1) begin
      errors++;
      $display("FAIL nak error: got %b expected 1", error);
    end
    push_expected(OP_XOR, 8'h0F, 8'h05);
    send_byte(OP_XOR);
    @(negedge clk);
    checks++;
    if (error !== 1'b0) begin
      errors++;
      $display("FAIL error_clear: got %b expected 0", error);
    end
    send_byte(8'h0F);
    send_byte(8'h05);
    drain("xor");
  endtask

  task automatic test_timeout();
    int start;
    start = tx_start_cnt;
    send_byte(OP_ADD);
    send_byte(8'h05);
    repeat (60) @(posedge clk);
    @(negedge clk);
    checks++;
    if (tx_start_cnt != start || state_dbg !== 3'd0 || error !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL timeout: got starts=%0d st=%0d err=%b busy=%b expected 0 0 1 0",
               tx_start_cnt - start, state_dbg, error, busy);
    end
  endtask

  task automatic test_reset_mid_tx();
    int n;
    send_byte(OP_ADD);
    send_byte(8'h05);
    send_byte(8'h07);
    n = 0;
    @(negedge clk);
    while (bus.tx_start !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.tx_start !== 1'b1 || state_dbg !== 3'd4) begin
      errors++;
      $display("FAIL mid_tx_reach: got start=%b st=%0d expected 1 4", bus.tx_start, state_dbg);
    end
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset_mid_tx");
    reset = 1'b1;
    test_packet("after_reset", OP_ADD, 8'h01, 8'h01);
  endtask

  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    bus.tx_done  = 1'b0;
    test_reset();
    test_packet("add", OP_ADD, 8'h05, 8'h07);
    test_packet("mul", OP_MUL, 8'hFF, 8'hFF);
    test_packet("sub", OP_SUB, 8'h05, 8'h07);
    test_nak_then_xor();
    test_timeout();
    test_reset_mid_tx();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
